// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator for VGA-style video modes. A clock-per-pixel
// divider produces a pixel tick; on each tick the horizontal counter steps,
// and the vertical counter steps when a line wraps. Sync, blanking,
// data-enable and a look-ahead fetch coordinate are decoded from the
// *next* counter values and registered, so every output describes the
// current (hc, vc) with no added latency.
//
// Line layout (columns) and frame layout (lines):
//   visible | front porch | sync pulse | back porch
// The origin (0,0) is the first visible pixel.
//
// Ports
//   clk          system clock (only clock)
//   clr          synchronous active-high reset; overrides en
//   en           run enable; low freezes all timing
//   pix_en       high on the first clk of each pixel period
//   hsync/vsync  sync outputs at H_SYNC_POL / V_SYNC_POL active level
//   hblank       high outside visible columns
//   vblank       high outside visible lines
//   de           ~hblank & ~vblank
//   x, y         current column / line (raw, also during blanking)
//   line_start   one-clk pulse when x becomes 0
//   frame_start  one-clk pulse when (x,y) becomes (0,0)
//   fetch_x/y    position LEAD pixels ahead of (x,y), wrapping line/frame
//   fetch_de     data-enable of the fetch position
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int CLK_DIV    = 2,
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_PULSE    = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_PULSE    = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int LEAD       = 0,
    parameter int X_BITS     = 12,
    parameter int Y_BITS     = 12
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    output logic              pix_en,
    output logic              hsync,
    output logic              vsync,
    output logic              hblank,
    output logic              vblank,
    output logic              de,
    output logic [X_BITS-1:0] x,
    output logic [Y_BITS-1:0] y,
    output logic              line_start,
    output logic              frame_start,
    output logic [X_BITS-1:0] fetch_x,
    output logic [Y_BITS-1:0] fetch_y,
    output logic              fetch_de
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_PULSE + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_PULSE + V_BP;
    localparam int D_BITS  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [D_BITS-1:0] D_MAX = D_BITS'(CLK_DIV - 1);
    localparam logic [D_BITS-1:0] D_ONE = D_BITS'(1);

    localparam logic [X_BITS-1:0] H_LAST     = X_BITS'(H_TOTAL - 1);
    localparam logic [X_BITS-1:0] H_VIS      = X_BITS'(H_VISIBLE);
    localparam logic [X_BITS-1:0] H_SYNC_ON  = X_BITS'(H_VISIBLE + H_FP);
    localparam logic [X_BITS-1:0] H_SYNC_OFF = X_BITS'(H_VISIBLE + H_FP + H_PULSE);
    localparam logic [X_BITS-1:0] X_ONE      = X_BITS'(1);

    localparam logic [Y_BITS-1:0] V_LAST     = Y_BITS'(V_TOTAL - 1);
    localparam logic [Y_BITS-1:0] V_VIS      = Y_BITS'(V_VISIBLE);
    localparam logic [Y_BITS-1:0] V_SYNC_ON  = Y_BITS'(V_VISIBLE + V_FP);
    localparam logic [Y_BITS-1:0] V_SYNC_OFF = Y_BITS'(V_VISIBLE + V_FP + V_PULSE);
    localparam logic [Y_BITS-1:0] Y_ONE      = Y_BITS'(1);

    // One extra bit so hc+LEAD (< 2*H_TOTAL) never overflows.
    localparam logic [X_BITS:0] LEAD_W    = (X_BITS+1)'(LEAD);
    localparam logic [X_BITS:0] H_TOTAL_W = (X_BITS+1)'(H_TOTAL);

    // Counter state and its next value.
    logic [D_BITS-1:0] d,  d_nx;
    logic [X_BITS-1:0] hc, hc_nx;
    logic [Y_BITS-1:0] vc, vc_nx;
    logic              tick;

    // Position that the registered decodes will describe after this edge.
    logic [X_BITS-1:0] pos_h;
    logic [Y_BITS-1:0] pos_v;

    // Decodes of pos_h / pos_v.
    logic              hblank_c, vblank_c, hsync_c, vsync_c;
    logic [X_BITS:0]   fx_sum;
    logic              fx_wrap;
    logic [X_BITS-1:0] fx_c;
    logic [Y_BITS-1:0] fy_c;
    logic              fde_c;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        tick  = en && (d == D_MAX);
        d_nx  = d;
        hc_nx = hc;
        vc_nx = vc;
        if (tick) begin
            d_nx = '0;
            if (hc == H_LAST) begin
                hc_nx = '0;
                vc_nx = (vc == V_LAST) ? '0 : vc + Y_ONE;
            end else begin
                hc_nx = hc + X_ONE;
            end
        end else if (en) begin
            d_nx = d + D_ONE;
        end
    end

    // During reset the decoders look at the reset position, so the outputs
    // load the decode of (H_TOTAL-1, V_TOTAL-1) through the normal path.
    always_comb begin
        pos_h = clr ? H_LAST : hc_nx;
        pos_v = clr ? V_LAST : vc_nx;

        hblank_c = (pos_h >= H_VIS);
        vblank_c = (pos_v >= V_VIS);
        hsync_c  = ((pos_h >= H_SYNC_ON) && (pos_h < H_SYNC_OFF)) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_c  = ((pos_v >= V_SYNC_ON) && (pos_v < V_SYNC_OFF)) ? V_SYNC_POL : ~V_SYNC_POL;

        // Look-ahead wraps into the next line (and frame) past the line end.
        fx_sum  = {1'b0, pos_h} + LEAD_W;
        fx_wrap = (fx_sum >= H_TOTAL_W);
        fx_c    = fx_wrap ? X_BITS'(fx_sum - H_TOTAL_W) : fx_sum[X_BITS-1:0];
        if (fx_wrap)
            fy_c = (pos_v == V_LAST) ? '0 : pos_v + Y_ONE;
        else
            fy_c = pos_v;
        fde_c = (fx_c < H_VIS) && (fy_c < V_VIS);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clr) begin
            d           <= D_MAX;
            hc          <= H_LAST;
            vc          <= V_LAST;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            d           <= d_nx;
            hc          <= hc_nx;
            vc          <= vc_nx;
            pix_en      <= tick;
            line_start  <= tick && (hc_nx == '0);
            frame_start <= tick && (hc_nx == '0) && (vc_nx == '0);
        end
    end

    // NOTE: the decoded outputs have no separate reset branch; clr forces
    // them to load the reset-position decode, and otherwise they reload only
    // on a pixel tick, which makes them hold while en is low.
    always_ff @(posedge clk) begin
        if (clr || tick) begin
            hsync    <= hsync_c;
            vsync    <= vsync_c;
            hblank   <= hblank_c;
            vblank   <= vblank_c;
            de       <= ~hblank_c & ~vblank_c;
            fetch_x  <= fx_c;
            fetch_y  <= fy_c;
            // The reset state reports no fetch data even when LEAD wraps the
            // reset position onto the first visible pixel.
            fetch_de <= fde_c & ~clr;
        end
    end

    // x / y are the counters themselves, already registered.
    assign x = hc;
    assign y = vc;

endmodule
